game_input_ctrl: RTL and testbench

- Player-input side of the reaction game; the counterpart to the timer/display path.
- Synchronises and debounces raw start/stop buttons, then runs the round FSM.
- Drives enable and clear into the game timer and consumes its done flag and 28-bit segment snapshot.
- Latches the displayed time when the player hits stop, for the result display.

---
 rtl/game_input_ctrl.sv | 165 ++++++++++++++++
 tb/tb_game_input_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/game_input_ctrl.sv
// Reaction-game input controller: button sync/debounce, round FSM, result capture.
// Optional false-start detection is enabled by defining GAME_INPUT_CTRL_FALSE_START_EN.
module game_input_ctrl #(
    parameter int DEB_N  = 16,
    parameter int SSEG_W = 28
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_start,
    input  logic              btn_stop,
    input  logic              timer_done,
    input  logic [SSEG_W-1:0] timer_sseg,
    output logic              timer_en,
    output logic              timer_clr,
    output logic              capture_valid,
    output logic [SSEG_W-1:0] capture_sseg,
    output logic              timeout,
    output logic              false_start,
    output logic [1:0]        state
);

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ARM    = 2'b01,
        RUN    = 2'b10,
        RESULT = 2'b11
    } state_t;

    logic [1:0] raw;
    logic [1:0] press;
    logic       start_press;
    logic       stop_press;

    assign raw         = {btn_stop, btn_start};
    assign start_press = press[0];
    assign stop_press  = press[1];

    // Index 0 = start, 1 = stop. Each button: 2-flop sync, saturating-count debounce, rising-edge pulse.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : deb_gen
            logic             sync1_reg;
            logic             sync2_reg;
            logic             stable_reg;
            logic             stable_d_reg;
            logic [DEB_N-1:0] cnt_reg;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    sync1_reg    <= 1'b0;
                    sync2_reg    <= 1'b0;
                    stable_reg   <= 1'b0;
                    stable_d_reg <= 1'b0;
                    cnt_reg      <= '0;
                end else begin
                    sync1_reg    <= raw[gi];
                    sync2_reg    <= sync1_reg;
                    stable_d_reg <= stable_reg;
                    if (sync2_reg != stable_reg) begin
                        if (cnt_reg == '1) begin
                            stable_reg <= sync2_reg;
                            cnt_reg    <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end else begin
                        cnt_reg <= '0;
                    end
                end
            end

            assign press[gi] = stable_reg & ~stable_d_reg;
        end
    endgenerate

`ifdef GAME_INPUT_CTRL_FALSE_START_EN
    localparam logic [SSEG_W-1:0] SSEG_F = SSEG_W'({(SSEG_W/7){7'b0001110}});
    logic stop_level;
    assign stop_level = deb_gen[1].stable_reg;
`endif

    state_t            state_reg, state_next;
    logic              timer_en_reg, timer_en_next;
    logic              timer_clr_reg, timer_clr_next;
    logic              capture_valid_reg, capture_valid_next;
    logic [SSEG_W-1:0] capture_sseg_reg, capture_sseg_next;
    logic              timeout_reg, timeout_next;
    logic              false_start_reg, false_start_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg         <= IDLE;
            timer_en_reg      <= 1'b0;
            timer_clr_reg     <= 1'b0;
            capture_valid_reg <= 1'b0;
            capture_sseg_reg  <= '1;
            timeout_reg       <= 1'b0;
            false_start_reg   <= 1'b0;
        end else begin
            state_reg         <= state_next;
            timer_en_reg      <= timer_en_next;
            timer_clr_reg     <= timer_clr_next;
            capture_valid_reg <= capture_valid_next;
            capture_sseg_reg  <= capture_sseg_next;
            timeout_reg       <= timeout_next;
            false_start_reg   <= false_start_next;
        end
    end

    always_comb begin
        state_next         = state_reg;
        capture_valid_next = capture_valid_reg;
        capture_sseg_next  = capture_sseg_reg;
        timeout_next       = timeout_reg;
        false_start_next   = false_start_reg;

        case (state_reg)
            IDLE, RESULT: begin
                if (start_press) begin
                    // A new round wipes the previous result as it enters ARM.
                    state_next         = ARM;
                    capture_valid_next = 1'b0;
                    capture_sseg_next  = '1;
                    timeout_next       = 1'b0;
                    false_start_next   = 1'b0;
`ifdef GAME_INPUT_CTRL_FALSE_START_EN
                    if (stop_level) begin
                        state_next         = RESULT;
                        capture_valid_next = 1'b1;
                        capture_sseg_next  = SSEG_F;
                        false_start_next   = 1'b1;
                    end
`endif
                end
            end
            ARM: state_next = RUN;
            RUN: begin
                // Stop has priority over a coincident timer expiry.
                if (stop_press) begin
                    state_next         = RESULT;
                    capture_valid_next = 1'b1;
                    capture_sseg_next  = timer_sseg;
                    timeout_next       = 1'b0;
                end else if (timer_done) begin
                    state_next         = RESULT;
                    capture_valid_next = 1'b1;
                    capture_sseg_next  = timer_sseg;
                    timeout_next       = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        timer_clr_next = (state_next == ARM);
        timer_en_next  = (state_next == RUN);
    end

    assign state         = state_reg;
    assign timer_en      = timer_en_reg;
    assign timer_clr     = timer_clr_reg;
    assign capture_valid = capture_valid_reg;
    assign capture_sseg  = capture_sseg_reg;
    assign timeout       = timeout_reg;
    assign false_start   = false_start_reg;

endmodule

// File: tb/tb_game_input_ctrl.sv
// Randomized self-checking bench for game_input_ctrl against a round-level reference model.
module tb_game_input_ctrl;

    localparam int          SSEG_W = 28;
    localparam logic [27:0] BLANK  = 28'hFFFFFFF;
    localparam logic [27:0] F_PAT  = 28'b0001110000111000011100001110;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              btn_start = 1'b0;
    logic              btn_stop = 1'b0;
    logic              timer_done = 1'b0;
    logic [SSEG_W-1:0] timer_sseg = '0;
    logic              timer_en, timer_clr, capture_valid, timeout, false_start;
    logic [SSEG_W-1:0] capture_sseg;
    logic [1:0]        state;

    game_input_ctrl #(.DEB_N(4), .SSEG_W(SSEG_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_start    (btn_start),
        .btn_stop     (btn_stop),
        .timer_done   (timer_done),
        .timer_sseg   (timer_sseg),
        .timer_en     (timer_en),
        .timer_clr    (timer_clr),
        .capture_valid(capture_valid),
        .capture_sseg (capture_sseg),
        .timeout      (timeout),
        .false_start  (false_start),
        .state        (state)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: round phase (0 idle, 1 arm, 2 run, 3 result) and the held result.
    int          m_phase = 0;
    logic        m_valid = 1'b0;
    logic [27:0] m_sseg  = BLANK;
    logic        m_tout  = 1'b0;
    logic        m_fs    = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_valid = 1'b0; m_sseg = BLANK; m_tout = 1'b0; m_fs = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".state"},    32'(state), 32'(m_phase));
        check({tag, ".en"},       32'(timer_en), 32'(m_phase == 2));
        check({tag, ".clr"},      32'(timer_clr), 32'(m_phase == 1));
        check({tag, ".valid"},    32'(capture_valid), 32'(m_valid));
        check({tag, ".sseg"},     32'(capture_sseg), 32'(m_sseg));
        check({tag, ".timeout"},  32'(timeout), 32'(m_tout));
        check({tag, ".fs"},       32'(false_start), 32'(m_fs));
    endtask

    // Raw start edge must reach ARM after 2 sync + 15 debounce + 1 edge + 1 register = 19 cycles.
    task automatic start_round();
        int lat = 0;
        btn_start = 1'b1;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            tick();
            if (timer_clr) lat = i;
        end
        check("start_latency", 32'(lat), 32'd19);
        m_phase = 1; m_valid = 1'b0; m_sseg = BLANK; m_tout = 1'b0; m_fs = 1'b0;
        check_outputs("arm");
        tick();
        m_phase = 2;
        check_outputs("run");
        tick(30 - lat - 1);
        btn_start = 1'b0;
        tick(25);
        check_outputs("run_hold");
        $display("start: ARM after %0d cycles, now RUN", lat);
    endtask

    task automatic stop_end(input logic [27:0] v);
        int lat = 0;
        timer_sseg = v;
        btn_stop = 1'b1;
        for (int i = 1; i <= 40 && lat == 0; i++) begin
            tick();
            if (state == 2'b11) lat = i;
        end
        check("stop_latency", 32'(lat), 32'd19);
        m_phase = 3; m_valid = 1'b1; m_sseg = v; m_tout = 1'b0;
        check_outputs("stop");
        timer_sseg = 28'($urandom);
        tick(30 - lat);
        btn_stop = 1'b0;
        tick(25);
        check_outputs("stop_hold");
        $display("stop: captured %h after %0d cycles", capture_sseg, lat);
    endtask

    task automatic timeout_end(input logic [27:0] v);
        timer_sseg = v;
        timer_done = 1'b1;
        tick();
        timer_done = 1'b0;
        timer_sseg = 28'($urandom);
        m_phase = 3; m_valid = 1'b1; m_sseg = v; m_tout = 1'b1;
        check_outputs("timeout");
        tick(5);
        check_outputs("timeout_hold");
        $display("timeout: captured %h", capture_sseg);
    endtask

    // Stop press pulse is live in the cycle after the 18th edge; timer_done is raised into it.
    task automatic both_end(input logic [27:0] v);
        timer_sseg = v;
        btn_stop = 1'b1;
        tick(18);
        check("pre_coincide.state", 32'(state), 32'd2);
        timer_done = 1'b1;
        tick();
        timer_done = 1'b0;
        m_phase = 3; m_valid = 1'b1; m_sseg = v; m_tout = 1'b0;
        check_outputs("coincide");
        tick(11);
        btn_stop = 1'b0;
        tick(25);
        check_outputs("coincide_hold");
        $display("coincide: stop+done captured %h timeout=%0b", capture_sseg, timeout);
    endtask

    task automatic press_ignored(input bit use_stop, input int len, input string tag);
        if (use_stop) btn_stop = 1'b1; else btn_start = 1'b1;
        tick(len);
        btn_stop = 1'b0;
        btn_start = 1'b0;
        tick(30);
        check_outputs(tag);
        $display("%s: %0d-cycle %s press, state=%0d", tag, len, use_stop ? "stop" : "start", state);
    endtask

    initial begin
        model_reset();
        tick(3);
        check_outputs("reset");
        rst = 1'b1;
        tick(2);
        press_ignored(1'b1, 30, "idle_stop_ignored");

        start_round();
        stop_end(28'b1000000111100110000001000000);
        press_ignored(1'b1, 30, "result_stop_ignored");

        start_round();
        timeout_end(28'b1111001100000010000001000000);

        start_round();
        press_ignored(1'b1, 10, "glitch10");
        press_ignored(1'b0, 30, "run_start_ignored");
        both_end(28'($urandom));

        for (int r = 0; r < 6; r++) begin
            int kind;
            start_round();
            tick($urandom_range(0, 20));
            if ($urandom_range(0, 1) == 1)
                press_ignored(1'b1, $urandom_range(1, 10), "glitch_rand");
            kind = $urandom_range(0, 2);
            $display("round %0d: outcome kind %0d", r, kind);
            case (kind)
                0:       stop_end(28'($urandom));
                1:       timeout_end(28'($urandom));
                default: both_end(28'($urandom));
            endcase
        end

        // Asynchronous reset in the middle of a round takes effect before the next edge.
        start_round();
        tick(3);
        rst = 1'b0;
        #1;
        model_reset();
        check_outputs("async_reset");
        tick(2);
        rst = 1'b1;
        tick(2);
        press_ignored(1'b1, 30, "post_reset_stop_ignored");

        begin
            bit clr_seen = 1'b0;
            btn_stop = 1'b1;
            tick(25);
            btn_start = 1'b1;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (timer_clr) clr_seen = 1'b1;
            end
            btn_start = 1'b0;
            tick(25);
`ifdef GAME_INPUT_CTRL_FALSE_START_EN
            check("fs.clr_seen", 32'(clr_seen), 32'd0);
            m_phase = 3; m_valid = 1'b1; m_sseg = F_PAT; m_tout = 1'b0; m_fs = 1'b1;
`else
            check("fs.clr_seen", 32'(clr_seen), 32'd1);
            m_phase = 2; m_valid = 1'b0; m_sseg = BLANK; m_tout = 1'b0; m_fs = 1'b0;
`endif
            check_outputs("false_start");
            $display("false_start: state=%0d false_start=%0b sseg=%h", state, false_start, capture_sseg);
            btn_stop = 1'b0;
            tick(25);
            check_outputs("false_start_release");
        end
`ifdef GAME_INPUT_CTRL_FALSE_START_EN
        start_round();
`endif
        stop_end(28'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
